// File: rtl/mac_result_serializer.sv
// Serializes a captured param_M x param_N result matrix into a valid/ready element stream.
// Optional MAC_SER_COLMAJOR_EN switches emission from row-major to column-major order.
module mac_result_serializer #(
    parameter int param_M          = 4,
    parameter int param_N          = 4,
    parameter int DATA_WIDTH_FINAL = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          host2block_val,
    output logic                                          host2block_rdy,
    input  logic [param_M*param_N*DATA_WIDTH_FINAL-1:0]   c_data_in,
    output logic                                          out_val,
    input  logic                                          out_rdy,
    output logic [DATA_WIDTH_FINAL-1:0]                   out_data,
    output logic [$clog2(param_M*param_N)-1:0]            out_idx,
    output logic                                          out_last,
    output logic [7:0]                                    frame_cnt
);

    localparam int NUM_EL = param_M * param_N;
    localparam int IDX_W  = $clog2(NUM_EL);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_EL - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic [IDX_W-1:0]            k_q, k_d;
    logic [7:0]                  frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH_FINAL-1:0] buf_q [NUM_EL];

    logic             streaming;
    logic             capture;
    logic             at_last;
    logic [IDX_W-1:0] elem_idx;

    assign streaming = (state_q == ST_STREAM);
    assign capture   = (state_q == ST_IDLE) && host2block_val;
    assign at_last   = (k_q == K_LAST);

`ifdef MAC_SER_COLMAJOR_EN
    int unsigned k_int;
    always_comb begin
        k_int    = 32'(k_q);
        elem_idx = IDX_W'((k_int % param_M) * param_N + (k_int / param_M));
    end
`else
    assign elem_idx = k_q;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (host2block_val) begin
                    state_d = ST_STREAM;
                    k_d     = '0;
                end
            end
            ST_STREAM: begin
                if (out_rdy) begin
                    if (at_last) begin
                        state_d     = ST_IDLE;
                        k_d         = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Buffer content is irrelevant outside STREAM, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            for (int i = 0; i < NUM_EL; i++) begin
                buf_q[i] <= c_data_in[i*DATA_WIDTH_FINAL +: DATA_WIDTH_FINAL];
            end
        end
    end

    assign host2block_rdy = !streaming;
    assign out_val        = streaming;
    assign out_data       = streaming ? buf_q[elem_idx] : '0;
    assign out_idx        = streaming ? elem_idx : '0;
    assign out_last       = streaming && at_last;
    assign frame_cnt      = frame_cnt_q;

endmodule
